// File: rtl/usd_apu_host.sv
// Host-side initiator for the micro-SD engine: queues one command (plus write payload),
// drains read payload, pops the result word and pulses done.
module usd_apu_host #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF,
  parameter int          BLOCK_WORDS    = 64
) (
  input  logic        apuClk,
  input  logic        sysRstN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [1:0]  reqOp,
  input  logic [5:0]  reqCmdIdx,
  input  logic [31:0] reqArg,
  input  logic [63:0] wrData,
  input  logic        wrDataValid,
  output logic        wrDataReady,
  output logic [63:0] rdData,
  output logic        rdDataValid,
  output logic        done,
  output logic [3:0]  doneStatus,
  output logic [31:0] doneResp,
  output logic [71:0] cmdFifoData,
  output logic        cmdFifoWrEn,
  input  logic        cmdFifoFull,
  output logic [71:0] writeFifoData,
  output logic        writeFifoWrEn,
  input  logic        writeFifoFull,
  input  logic [71:0] readFifoData,
  output logic        readFifoRdEn,
  input  logic        readFifoEmpty,
  input  logic [35:0] resultFifoData,
  output logic        resultFifoRdEn,
  input  logic        resultFifoEmpty
);

  localparam int            CW        = $clog2(BLOCK_WORDS + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_WORDS - 1);
  localparam logic [CW-1:0] ALL_WORDS = CW'(BLOCK_WORDS);
  localparam logic [23:0]   TO_LIMIT  = TIMEOUT_CYCLES - 24'd1;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] PUSH_WDATA  = 3'd1;
  localparam logic [2:0] SEND_CMD    = 3'd2;
  localparam logic [2:0] READ_DATA   = 3'd3;
  localparam logic [2:0] WAIT_RESULT = 3'd4;
  localparam logic [2:0] POP_RESULT  = 3'd5;
  localparam logic [2:0] DONE        = 3'd6;

  localparam logic [1:0] OP_RAW   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  logic [2:0]    state, stateNext;
  logic [1:0]    opReg;
  logic [5:0]    idxReg;
  logic [31:0]   argReg;
  logic [CW-1:0] wordCnt, issuedCnt, deliveredCnt;
  logic [23:0]   toCnt;
  logic          inTimed, progress, timedOut;
  logic [5:0]    cmdIdx;
  logic          unusedRdTag;

  // Strobes are decoded from state, so an async reset silences them in the same instant.
  assign reqReady       = (state == IDLE);
  assign done           = (state == DONE);
  assign wrDataReady    = (state == PUSH_WDATA) && !writeFifoFull;
  assign writeFifoWrEn  = wrDataReady && wrDataValid;
  assign writeFifoData  = (state == PUSH_WDATA) ? {8'h00, wrData} : 72'h0;
  assign cmdFifoWrEn    = (state == SEND_CMD) && !cmdFifoFull;
  assign readFifoRdEn   = (state == READ_DATA) && !readFifoEmpty && (issuedCnt < ALL_WORDS);
  assign resultFifoRdEn = (state == WAIT_RESULT) && !resultFifoEmpty;
  assign rdData         = rdDataValid ? readFifoData[63:0] : 64'h0;
  assign unusedRdTag    = ^readFifoData[71:64];

  assign cmdIdx      = (opReg == OP_READ) ? 6'd17 : (opReg == OP_WRITE) ? 6'd24 : idxReg;
  assign cmdFifoData = {8'h00, cmdIdx, 8'h00, (opReg != OP_RAW), (opReg == OP_WRITE),
                        16'h0000, argReg};

  assign inTimed = (state == PUSH_WDATA) || (state == SEND_CMD) ||
                   (state == READ_DATA)  || (state == WAIT_RESULT);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    progress  = 1'b0;
    timedOut  = 1'b0;
    case (state)
      IDLE:        if (reqValid) stateNext = (reqOp == OP_WRITE) ? PUSH_WDATA : SEND_CMD;
      PUSH_WDATA: begin
        progress = writeFifoWrEn;
        if (writeFifoWrEn && (wordCnt == LAST_WORD)) stateNext = SEND_CMD;
      end
      SEND_CMD:    if (cmdFifoWrEn) stateNext = (opReg == OP_READ) ? READ_DATA : WAIT_RESULT;
      READ_DATA: begin
        progress = readFifoRdEn || rdDataValid;
        if (rdDataValid && (deliveredCnt == LAST_WORD)) stateNext = WAIT_RESULT;
      end
      WAIT_RESULT: if (resultFifoRdEn) stateNext = POP_RESULT;
      POP_RESULT:  stateNext = DONE;
      DONE:        stateNext = IDLE;
      default:     stateNext = IDLE;
    endcase
    if (inTimed && !progress && (stateNext == state) && (toCnt == TO_LIMIT)) begin
      timedOut  = 1'b1;
      stateNext = DONE;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge apuClk or negedge sysRstN) begin
    if (!sysRstN) begin
      state        <= IDLE;
      opReg        <= OP_RAW;
      idxReg       <= 6'h0;
      argReg       <= 32'h0;
      wordCnt      <= '0;
      issuedCnt    <= '0;
      deliveredCnt <= '0;
      toCnt        <= 24'h0;
      rdDataValid  <= 1'b0;
      doneStatus   <= 4'h0;
      doneResp     <= 32'h0;
    end else begin
      state       <= stateNext;
      rdDataValid <= readFifoRdEn;

      if (state == IDLE) begin
        wordCnt      <= '0;
        issuedCnt    <= '0;
        deliveredCnt <= '0;
        if (reqValid) begin
          opReg  <= (reqOp == 2'b11) ? OP_RAW : reqOp;
          idxReg <= reqCmdIdx;
          argReg <= reqArg;
        end
      end else begin
        if (writeFifoWrEn) wordCnt      <= wordCnt + CW'(1);
        if (readFifoRdEn)  issuedCnt    <= issuedCnt + CW'(1);
        if (rdDataValid)   deliveredCnt <= deliveredCnt + CW'(1);
      end

      // Cleared on every state change and every handshake; only idle waiting accumulates.
      if ((stateNext != state) || progress) toCnt <= 24'h0;
      else if (inTimed)                     toCnt <= toCnt + 24'd1;

      if (timedOut) begin
        doneStatus <= 4'hF;
        doneResp   <= 32'h0;
      end else if (state == POP_RESULT) begin
        doneStatus <= resultFifoData[35:32];
        doneResp   <= resultFifoData[31:0];
      end
    end
  end

endmodule

// File: tb/tb_usd_apu_host.sv
// Directed bench for usd_apu_host: behavioural FIFO models, strobe monitors and
// hand-computed expectations for raw, write, read, backpressure, timeout and reset cases.
module tb_usd_apu_host;

  logic        apuClk = 1'b0;
  logic        sysRstN;
  logic        reqValid, reqReady;
  logic [1:0]  reqOp;
  logic [5:0]  reqCmdIdx;
  logic [31:0] reqArg;
  logic [63:0] wrData;
  logic        wrDataValid, wrDataReady;
  logic [63:0] rdData;
  logic        rdDataValid, done;
  logic [3:0]  doneStatus;
  logic [31:0] doneResp;
  logic [71:0] cmdFifoData, writeFifoData, readFifoData;
  logic        cmdFifoWrEn, cmdFifoFull, writeFifoWrEn, writeFifoFull;
  logic        readFifoRdEn, readFifoEmpty;
  logic [35:0] resultFifoData, resWord;
  logic        resultFifoRdEn, resultFifoEmpty;

  logic [71:0] rdMem [256];
  logic [7:0]  rdHead, rdTail, resPut, resGot;

  int errors = 0;
  int checks = 0;
  int cmdWrCount = 0, wrCount = 0, wrBad = 0, wrAtCmd = 0;
  int rdCount = 0, rdBad = 0, rdEnCount = 0, rdAtPop = 0;
  int doneCount = 0, fullViol = 0;
  int wrSeq = 0;

  always #5 apuClk = ~apuClk;

  usd_apu_host #(.TIMEOUT_CYCLES(24'd100), .BLOCK_WORDS(64)) dut (
    .apuClk(apuClk), .sysRstN(sysRstN),
    .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
    .reqCmdIdx(reqCmdIdx), .reqArg(reqArg),
    .wrData(wrData), .wrDataValid(wrDataValid), .wrDataReady(wrDataReady),
    .rdData(rdData), .rdDataValid(rdDataValid),
    .done(done), .doneStatus(doneStatus), .doneResp(doneResp),
    .cmdFifoData(cmdFifoData), .cmdFifoWrEn(cmdFifoWrEn), .cmdFifoFull(cmdFifoFull),
    .writeFifoData(writeFifoData), .writeFifoWrEn(writeFifoWrEn), .writeFifoFull(writeFifoFull),
    .readFifoData(readFifoData), .readFifoRdEn(readFifoRdEn), .readFifoEmpty(readFifoEmpty),
    .resultFifoData(resultFifoData), .resultFifoRdEn(resultFifoRdEn),
    .resultFifoEmpty(resultFifoEmpty)
  );

  // Non-FWFT read and result FIFO models: data appears the cycle after the pop.
  assign readFifoEmpty   = (rdHead == rdTail);
  assign resultFifoEmpty = (resPut == resGot);

  initial begin
    rdHead = 8'd0;
    resGot = 8'd0;
    readFifoData = 72'h0;
    resultFifoData = 36'h0;
  end

  always @(posedge apuClk) begin
    if (readFifoRdEn && !readFifoEmpty) begin
      readFifoData <= rdMem[rdHead];
      rdHead       <= rdHead + 8'd1;
    end
    if (resultFifoRdEn && !resultFifoEmpty) begin
      resultFifoData <= resWord;
      resGot         <= resGot + 8'd1;
    end
  end

  always @(posedge apuClk) begin
    if (cmdFifoWrEn) begin
      cmdWrCount <= cmdWrCount + 1;
      wrAtCmd    <= wrCount;
    end
    if (writeFifoWrEn) begin
      if (writeFifoData !== {8'h00, 64'(wrCount)}) wrBad <= wrBad + 1;
      wrCount <= wrCount + 1;
    end
    if (rdDataValid) begin
      if (rdData !== {16'hA5A5, 40'h0, 8'(rdCount)}) rdBad <= rdBad + 1;
      rdCount <= rdCount + 1;
    end
    if (readFifoRdEn)   rdEnCount <= rdEnCount + 1;
    if (resultFifoRdEn) rdAtPop   <= rdCount;
    if (done)           doneCount <= doneCount + 1;
    if ((cmdFifoWrEn && cmdFifoFull) || (writeFifoWrEn && writeFifoFull) ||
        (readFifoRdEn && readFifoEmpty) || (resultFifoRdEn && resultFifoEmpty))
      fullViol <= fullViol + 1;
  end

  task automatic check(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] idx, input logic [31:0] arg);
    reqOp = op; reqCmdIdx = idx; reqArg = arg; reqValid = 1'b1;
    @(posedge apuClk); #1;
    reqValid = 1'b0;
  endtask

  task automatic pushResult(input logic [35:0] w);
    resWord = w;
    resPut  = resPut + 8'd1;
  endtask

  task automatic waitDone(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(posedge apuClk); #1;
      n++;
    end
  endtask

  task automatic pushWord();
    wrData = 64'(wrSeq); wrDataValid = 1'b1;
    @(posedge apuClk); #1;
    wrSeq++;
  endtask

  int n, c0, w0;

  initial begin
    sysRstN = 1'b0; reqValid = 1'b0; reqOp = 2'b00; reqCmdIdx = 6'h0; reqArg = 32'h0;
    wrData = 64'h0; wrDataValid = 1'b0; cmdFifoFull = 1'b0; writeFifoFull = 1'b0;
    rdTail = 8'd0; resPut = 8'd0; resWord = 36'h0;

    // Reset state
    repeat (3) @(posedge apuClk); #1;
    check("rst_reqReady", reqReady, 1'b1);
    check("rst_strobes", {cmdFifoWrEn, writeFifoWrEn, readFifoRdEn, resultFifoRdEn,
                          done, rdDataValid, wrDataReady}, 7'h0);
    check("rst_outputs", {doneStatus, doneResp}, 36'h0);
    check("rst_cmdData", cmdFifoData, 72'h0);
    sysRstN = 1'b1;
    @(posedge apuClk); #1;

    // Raw command
    issue(2'b00, 6'd8, 32'h1AA);
    check("raw_busy", reqReady, 1'b0);
    check("raw_cmdWrEn", cmdFifoWrEn, 1'b1);
    check("raw_cmdData", cmdFifoData, 72'h00_2000_0000_0000_01AA);
    pushResult(36'h0_000001AA);
    waitDone(50, n);
    check("raw_done", done, 1'b1);
    check("raw_status", doneStatus, 4'h0);
    check("raw_resp", doneResp, 32'h1AA);
    check("raw_cmdCount", cmdWrCount, 1);
    @(posedge apuClk); #1;
    check("raw_readyAfter", reqReady, 1'b1);

    // Block write, with a short write-FIFO stall
    issue(2'b10, 6'd0, 32'd5);
    check("wr_dataReady", wrDataReady, 1'b1);
    check("wr_noCmdYet", cmdFifoWrEn, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if (i == 10) begin
        writeFifoFull = 1'b1; wrData = 64'(wrSeq); wrDataValid = 1'b1; #1;
        check("wr_stallStrobe", {writeFifoWrEn, wrDataReady}, 2'b00);
        repeat (2) @(posedge apuClk); #1;
        writeFifoFull = 1'b0;
      end
      pushWord();
    end
    wrDataValid = 1'b0;
    check("wr_count", wrCount, 64);
    check("wr_dataErrs", wrBad, 0);
    pushResult(36'h3_00000ABC);
    check("wr_cmdWrEn", cmdFifoWrEn, 1'b1);
    check("wr_cmdData", cmdFifoData, 72'h00_6003_0000_0000_0005);
    waitDone(50, n);
    check("wr_done", done, 1'b1);
    check("wr_cmdAfterPayload", wrAtCmd, 64);
    check("wr_status", doneStatus, 4'h3);
    check("wr_resp", doneResp, 32'hABC);
    @(posedge apuClk); #1;

    // Block read: 66 words queued, exactly 64 must be taken; result already waiting
    for (int k = 0; k < 66; k++) begin
      rdMem[rdTail] = {8'hFF, 16'hA5A5, 40'h0, 8'(k)};
      rdTail = rdTail + 8'd1;
    end
    pushResult(36'h0_00000900);
    issue(2'b01, 6'd3, 32'd7);
    check("rd_cmdWrEn", cmdFifoWrEn, 1'b1);
    check("rd_cmdData", cmdFifoData, 72'h00_4402_0000_0000_0007);
    waitDone(200, n);
    check("rd_done", done, 1'b1);
    check("rd_validCount", rdCount, 64);
    check("rd_dataErrs", rdBad, 0);
    check("rd_rdEnCount", rdEnCount, 64);
    check("rd_popAfterData", rdAtPop, 64);
    check("rd_status", doneStatus, 4'h0);
    check("rd_resp", doneResp, 32'h900);
    @(posedge apuClk); #1;

    // Command FIFO full for 10 cycles; op 11 behaves as raw
    cmdFifoFull = 1'b1;
    issue(2'b11, 6'd55, 32'hDEADBEEF);
    c0 = cmdWrCount;
    check("full_noStrobe", cmdFifoWrEn, 1'b0);
    repeat (10) @(posedge apuClk); #1;
    check("full_heldCount", cmdWrCount, c0);
    cmdFifoFull = 1'b0; #1;
    check("full_releaseStrobe", cmdFifoWrEn, 1'b1);
    check("full_cmdData", cmdFifoData, 72'h00_DC00_0000_DEAD_BEEF);
    pushResult(36'h5_12345678);
    @(posedge apuClk); #1;
    check("full_oneWrite", cmdWrCount, c0 + 1);
    check("full_strobeDrop", cmdFifoWrEn, 1'b0);
    waitDone(50, n);
    check("full_done", done, 1'b1);
    check("full_status", doneStatus, 4'h5);
    check("full_resp", doneResp, 32'h12345678);
    @(posedge apuClk); #1;

    // Result never arrives
    issue(2'b00, 6'd13, 32'h0);
    check("to_cmdWrEn", cmdFifoWrEn, 1'b1);
    @(posedge apuClk); #1;
    waitDone(200, n);
    check("to_done", done, 1'b1);
    check("to_latency", n, 100);
    check("to_status", doneStatus, 4'hF);
    check("to_resp", doneResp, 32'h0);
    @(posedge apuClk); #1;
    check("to_readyAfter", {reqReady, done}, 2'b10);

    // Async reset after 30 payload words
    issue(2'b10, 6'd0, 32'd9);
    for (int i = 0; i < 30; i++) pushWord();
    sysRstN = 1'b0; #1;
    check("arst_strobes", {writeFifoWrEn, wrDataReady, cmdFifoWrEn, readFifoRdEn,
                           resultFifoRdEn, done}, 6'h0);
    check("arst_ready", reqReady, 1'b1);
    check("arst_status", doneStatus, 4'h0);
    w0 = wrCount;
    check("arst_wordsBefore", w0, 94);
    repeat (2) @(posedge apuClk); #1;
    check("arst_noMoreWrites", wrCount, w0);
    wrDataValid = 1'b0;
    sysRstN = 1'b1;
    @(posedge apuClk); #1;
    check("arst_readyAfter", reqReady, 1'b1);
    pushResult(36'h0_00000042);
    issue(2'b00, 6'd2, 32'h42);
    check("arst_cmdData", cmdFifoData, 72'h00_0800_0000_0000_0042);
    check("arst_cmdWrEn", cmdFifoWrEn, 1'b1);
    waitDone(50, n);
    check("arst_done", done, 1'b1);
    check("arst_resp", {doneStatus, doneResp}, 36'h0_00000042);
    @(posedge apuClk); #1;

    check("end_flagViolations", fullViol, 0);
    check("end_rdEnCount", rdEnCount, 64);
    check("end_doneCycles", doneCount, 6);
    check("end_cmdCount", cmdWrCount, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
